mem_latency_responder: RTL and testbench
========================================

# mem_latency_responder

Cycle-accurate main-memory responder for the L1 cache's miss/writeback path: it accepts one line request at a time, waits a programmable first-word latency with a down-counter, then returns a full line as a burst of word beats in critical-word-first, wrapping order. It is the responder end of the cache's memory request interface. It is used both in cache testbenches and as the timing model behind the memory array.

## Interface
- ADDR_W, 32, request/response address width
- LAT_W, 8, latency counter width
- BEATS, 4, words per line; power of two, ≥2
- WORD_BYTES, 4, bytes per word; power of two

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- hold  in  1  global stall; freezes all state
- req_valid  in  1  request present
- req_write  in  1  1 = writeback, 0 = refill
- req_addr  in  ADDR_W  byte address of the requested word
- lat_cfg  in  LAT_W  first-word latency in cycles, sampled at acceptance
- req_ready  out  1  = (state==IDLE) && !hold
- resp_valid  out  1  one beat valid; = (state==BURST) && !hold
- resp_write  out  1  captured req_write
- resp_last  out  1  final beat of line
- resp_beat  out  log2(BEATS)  word index within line
- resp_addr  out  ADDR_W  line base + resp_beat*WORD_BYTES
- busy  out  1  state != IDLE
- wait_cnt  out  LAT_W  remaining latency count

## Operation
- States: IDLE, WAIT, BURST.
- Reset (async, while reset=0): state=IDLE, counter=0, beat count k=0, captured regs=0. All outputs read 0, except req_ready, which follows !hold.
- Accept on a rising edge with req_valid && req_ready. At acceptance:
  - Capture line base = req_addr with low log2(BEATS*WORD_BYTES) bits cleared.
  - Capture start word s = req_addr[word index bits] and req_write.
  - Compute L = max(lat_cfg,1). Load counter = L-1. Set k=0. Go to WAIT.
- WAIT, each edge with !hold:
  - counter==0: go to BURST.
  - Otherwise: counter decrements.
- BURST:
  - resp_beat = (s+k) mod BEATS, which wraps within the line.
  - resp_last = (k==BEATS-1).
  - Each edge with !hold: k increments. If resp_last is set, go to IDLE instead.
- hold=1 freezes state, counter and k. It blocks acceptance and masks resp_valid, so no beat is duplicated or lost.
- Refills and writebacks have identical timing. For writebacks, resp_valid acknowledges the write data word.
- wait_cnt = counter in WAIT and 0 in the other states. Counter arithmetic never underflows.

## Timing
- Acceptance edge E0.
- With no hold, the first resp_valid is high in the cycle after edge E_L. That is L cycles after acceptance; lat_cfg=0 behaves as L=1.
- Beats follow on BEATS consecutive cycles. The return to IDLE happens on the edge that consumes the last beat.
- req_ready rises in the cycle after the last beat, so there is at least one idle cycle between transactions.
- Each hold cycle adds exactly one cycle of delay at the point where it occurs.
- Reset asserted mid-transaction aborts it immediately. No further beats are produced, and the next request is accepted normally after reset deasserts.
- req_valid while not ready is ignored. The requester holds the request stable until accepted.

## Structure
- Package mem_resp_pkg holds:
  - state enum (IDLE, WAIT, BURST)
  - localparam helpers: BEAT_W=$clog2(BEATS), OFF_W=$clog2(BEATS*WORD_BYTES), WORD_OFF=$clog2(WORD_BYTES)
- Sub-module lat_down_counter (parameter LAT_W): ports clk, reset (async active-low), load, load_val, hold, cnt, zero. It decrements when neither load nor hold is asserted and cnt≠0.
- FSM, address/beat logic and output decode live in the top module.

## Test plan
- Refill: lat_cfg=3, req_addr=0x100, no hold -> beats on cycles 3..6 after acceptance. resp_beat 0,1,2,3; resp_addr 0x100/0x104/0x108/0x10C; resp_last on the 4th beat; req_ready high the following cycle.
- Critical word wrap: req_addr=0x208, lat_cfg=1 -> resp_beat 2,3,0,1; resp_addr 0x208, 0x20C, 0x200, 0x204; first beat 1 cycle after acceptance.
- lat_cfg=0 -> identical timing to lat_cfg=1; wait_cnt stays 0.
- Hold: lat_cfg=4, hold for 2 cycles during WAIT and 1 cycle on beat 1 -> first beat at 6 cycles; beat 1 appears exactly once, delayed by 1; total 3 extra cycles.
- Reset mid-burst: assert reset=0 during beat 2 -> outputs zero at once and state is IDLE. After release, a writeback with lat_cfg=2 completes normally with resp_write=1.
- Back-pressure: req_valid held high continuously across two transactions -> the second is accepted only when req_ready=1, after one idle cycle; no request is accepted during hold.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and geometry helpers for the main-memory latency responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_e;

  localparam int unsigned DEF_BEATS      = 4;
  localparam int unsigned DEF_WORD_BYTES = 4;
  localparam int unsigned BEAT_W   = $clog2(DEF_BEATS);
  localparam int unsigned OFF_W    = $clog2(DEF_BEATS * DEF_WORD_BYTES);
  localparam int unsigned WORD_OFF = $clog2(DEF_WORD_BYTES);

  // Parameterised forms of the geometry helpers, usable as constant functions.
  function automatic int unsigned beat_w(input int unsigned beats);
    return $clog2(beats);
  endfunction

  function automatic int unsigned off_w(input int unsigned beats, input int unsigned word_bytes);
    return $clog2(beats * word_bytes);
  endfunction

  function automatic int unsigned word_off(input int unsigned word_bytes);
    return $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/mem_latency_responder_counter.sv
// Loadable latency down-counter that saturates at zero and freezes under hold.
module lat_down_counter #(
  parameter int unsigned LAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             hold,
  output logic [LAT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_latency_responder.sv
// Line-request responder: programmable first-word latency, then a
// critical-word-first wrapping burst of BEATS word beats.
module mem_latency_responder
  import mem_resp_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned LAT_W      = 8,
  parameter  int unsigned BEATS      = 4,
  parameter  int unsigned WORD_BYTES = 4,
  localparam int unsigned BW         = beat_w(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LAT_W-1:0]  lat_cfg,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_write,
  output logic              resp_last,
  output logic [BW-1:0]     resp_beat,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              busy,
  output logic [LAT_W-1:0]  wait_cnt
);

  localparam int unsigned OW = off_w(BEATS, WORD_BYTES);
  localparam int unsigned WO = word_off(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BEATS * WORD_BYTES - 1);

  state_e            state;
  logic [ADDR_W-1:0] base_q;
  logic [BW-1:0]     start_q;
  logic [BW-1:0]     k_q;
  logic              write_q;

  logic              accept;
  logic [LAT_W-1:0]  lat_m1;
  logic [LAT_W-1:0]  cnt;
  logic              cnt_zero;
  logic [BW-1:0]     beat;
  logic              last_k;
  logic              in_burst;

  assign accept = req_valid && req_ready;
  // lat_cfg of 0 is treated as 1, so the load value never underflows.
  assign lat_m1 = (lat_cfg == '0) ? '0 : lat_cfg - 1'b1;

  lat_down_counter #(
    .LAT_W(LAT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(lat_m1),
    .hold    (hold),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  // BEATS is a power of two, so the BW-bit sum wraps within the line.
  assign beat   = start_q + k_q;
  assign last_k = (k_q == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      k_q     <= '0;
      write_q <= 1'b0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_q  <= req_addr & ~LINE_MASK;
            start_q <= req_addr[OW-1:WO];
            k_q     <= '0;
            write_q <= req_write;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_zero) state <= BURST;
        end
        BURST: begin
          if (last_k) state <= IDLE;
          else        k_q   <= k_q + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_burst   = (state == BURST);
  assign req_ready  = (state == IDLE) && !hold;
  assign resp_valid = in_burst && !hold;
  assign busy       = (state != IDLE);
  assign resp_write = write_q;
  assign resp_last  = in_burst && last_k;
  assign resp_beat  = in_burst ? beat : '0;
  assign resp_addr  = in_burst ? (base_q + (ADDR_W'(beat) << WO)) : '0;
  assign wait_cnt   = (state == WAIT) ? cnt : '0;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed + randomized bench for mem_latency_responder against a
// transaction-level model (latency countdown plus a queue of expected beats).
module tb_mem_latency_responder;

  localparam int ADDR_W = 32;
  localparam int LAT_W  = 8;
  localparam int BEATS  = 4;
  localparam int WB     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LAT_W-1:0]  lat_cfg = '0;
  logic              req_ready, resp_valid, resp_write, resp_last, busy;
  logic [1:0]        resp_beat;
  logic [ADDR_W-1:0] resp_addr;
  logic [LAT_W-1:0]  wait_cnt;

  always #5 clk = ~clk;

  mem_latency_responder #(
    .ADDR_W(ADDR_W), .LAT_W(LAT_W), .BEATS(BEATS), .WORD_BYTES(WB)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr), .lat_cfg(lat_cfg),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_write(resp_write),
    .resp_last(resp_last), .resp_beat(resp_beat), .resp_addr(resp_addr),
    .busy(busy), .wait_cnt(wait_cnt)
  );

  typedef struct {
    logic [1:0]  beat;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t q[$];
  bit    m_busy = 1'b0;
  int    lat_left = 0;
  logic  m_write = 1'b0;
  int    nvalid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    lat_left = 0;
    m_write = 1'b0;
    q.delete();
  endtask

  // What one rising edge does to the transaction, given the inputs seen at it.
  task automatic model_edge();
    int L;
    int s;
    logic [31:0] base;
    if (!reset || hold) return;
    if (!m_busy) begin
      if (req_valid) begin
        L = (lat_cfg == 0) ? 1 : int'(lat_cfg);
        base = req_addr & ~32'(BEATS * WB - 1);
        s = int'((req_addr % (BEATS * WB)) / WB);
        lat_left = L;
        m_write = req_write;
        q.delete();
        for (int k = 0; k < BEATS; k++)
          q.push_back('{beat: 2'((s + k) % BEATS),
                        addr: base + 32'(((s + k) % BEATS) * WB),
                        last: (k == BEATS - 1)});
        m_busy = 1'b1;
      end
    end else if (lat_left > 0) begin
      lat_left--;
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) m_busy = 1'b0;
    end
  endtask

  task automatic check_all();
    bit exp_valid;
    exp_valid = m_busy && (lat_left == 0) && !hold;
    if (resp_valid) nvalid++;
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !hold));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    chk("wait_cnt", 32'(wait_cnt), (m_busy && lat_left > 0) ? 32'(lat_left - 1) : 32'd0);
    chk("resp_write", 32'(resp_write), 32'(m_write));
    if (m_busy && lat_left == 0 && q.size() > 0) begin
      chk("resp_beat", 32'(resp_beat), 32'(q[0].beat));
      chk("resp_addr", resp_addr, q[0].addr);
      chk("resp_last", 32'(resp_last), 32'(q[0].last));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_beat"}, 32'(resp_beat), 32'd0);
    chk({tag, "_addr"}, resp_addr, 32'd0);
    chk({tag, "_last"}, 32'(resp_last), 32'd0);
    chk({tag, "_write"}, 32'(resp_write), 32'd0);
    chk({tag, "_wait"}, 32'(wait_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'(!hold));
  endtask

  task automatic tick(input logic h, input logic v, input logic w,
                      input logic [31:0] a, input logic [7:0] l);
    @(posedge clk);
    model_edge();
    #1;
    hold = h; req_valid = v; req_write = w; req_addr = a; lat_cfg = l;
    #1;
    check_all();
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    model_reset();
    check_zero("rst");
    hold = 1'b1;
    #1 check_zero("rst_hold");
    hold = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Refill at 0x100, latency 3.
    tick(0, 1, 0, 32'h100, 8'd3);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0);

    // Critical-word-first wrap from 0x208, latency 1.
    tick(0, 1, 0, 32'h208, 8'd1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);

    // lat_cfg = 0 behaves as 1.
    tick(0, 1, 1, 32'h30C, 8'd0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);

    // Hold twice in WAIT and once on beat 1; exactly BEATS beats must appear.
    tick(0, 1, 0, 32'h400, 8'd4);
    nvalid = 0;
    for (int i = 1; i <= 14; i++) tick((i == 1 || i == 2 || i == 8), 0, 0, 0, 0);
    chk("hold_beat_count", 32'(nvalid), 32'(BEATS));

    // Reset in the middle of a burst, during beat 2.
    tick(0, 1, 0, 32'h500, 8'd1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_zero("mid_rst");
    tick(0, 1, 0, 32'h540, 8'd1);
    check_zero("rst_held");
    @(negedge clk) reset = 1'b1;
    req_valid = 1'b0;
    tick(0, 1, 1, 32'h604, 8'd2);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0);

    // Back-pressure: request held valid through two transactions, with hold while idle.
    for (int i = 0; i < 14; i++) tick((i == 6 || i == 7), 1, 0, 32'h70C, 8'd1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, 8'($urandom_range(0, 6)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
